alu_input_sequencer: RTL and testbench

//   Upstream operand front-end for the ALU board demo. It debounces a raw

---
 rtl/alu_input_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_input_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_sequencer.sv
// Operand front-end for the ALU board demo: synchronises and debounces a raw
// pushbutton, then steps through loading operand A, operand B and the opcode
// from the switches. All outputs are registered.
module alu_input_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        btn_n,
  input  logic [16:0] sw_data,
  input  logic [3:0]  sw_op,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output logic [3:0]  aluop,
  output logic        op_valid,
  output logic [1:0]  state
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLoadA  = 2'd0,
    StLoadB  = 2'd1,
    StLoadOp = 2'd2,
    StShow   = 2'd3
  } state_e;

  logic             sync1_q, smp_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  state_e           state_q, state_d;
  logic [31:0]      port_a_q, port_a_d;
  logic [31:0]      port_b_q, port_b_d;
  logic [3:0]       aluop_q, aluop_d;
  logic             op_valid_q, op_valid_d;
  logic [31:0]      sw_sext;

  assign sw_sext = {{16{sw_data[16]}}, sw_data[15:0]};

  // Two-flop synchroniser plus debounced level and its stability counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1_q <= 1'b1;
      smp_q   <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      smp_q   <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the debounced level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (smp_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = smp_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accepted falling edge only; the release is debounced but silent.
  assign press = deb_q && !smp_q && (cnt_q == CntMax);

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StLoadA;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: advance only on an accepted press.
  always_comb begin
    state_d = state_q;
    if (press) begin
      unique case (state_q)
        StLoadA:  state_d = StLoadB;
        StLoadB:  state_d = StLoadOp;
        StLoadOp: state_d = StShow;
        StShow:   state_d = StLoadB;
        default:  state_d = StLoadA;
      endcase
    end
  end

  // FSM outputs: next values of the operand/opcode registers and op_valid.
  always_comb begin
    port_a_d   = port_a_q;
    port_b_d   = port_b_q;
    aluop_d    = aluop_q;
    op_valid_d = 1'b0;
    if (press) begin
      unique case (state_q)
        StLoadA:  port_a_d = sw_sext;
        StLoadB:  port_b_d = sw_sext;
        StLoadOp: begin
          aluop_d    = sw_op;
          op_valid_d = 1'b1;
        end
        StShow:   port_a_d = sw_sext;
        default:  ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      port_a_q   <= '0;
      port_b_q   <= '0;
      aluop_q    <= '0;
      op_valid_q <= 1'b0;
    end else begin
      port_a_q   <= port_a_d;
      port_b_q   <= port_b_d;
      aluop_q    <= aluop_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign port_a   = port_a_q;
  assign port_b   = port_b_q;
  assign aluop    = aluop_q;
  assign op_valid = op_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: directed scenarios plus randomized presses,
// with completed operations checked by a scoreboard on op_valid.
module tb_alu_input_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        btn_n;
  logic [16:0] sw_data;
  logic [3:0]  sw_op;
  logic [31:0] port_a, port_b;
  logic [3:0]  aluop;
  logic        op_valid;
  logic [1:0]  state;

  alu_input_sequencer #(.DEBOUNCE_CYCLES(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .btn_n    (btn_n),
    .sw_data  (sw_data),
    .sw_op    (sw_op),
    .port_a   (port_a),
    .port_b   (port_b),
    .aluop    (aluop),
    .op_valid (op_valid),
    .state    (state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } op_t;

  op_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: which slot the next press fills, and current contents.
  int          m_state;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [16:0] d);
    return 32'($signed(d));
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_a = '0;
    m_b = '0;
    m_op = '0;
  endtask

  // Apply the effect of one accepted press to the model.
  task automatic model_press(input logic [16:0] d, input logic [3:0] op);
    case (m_state)
      0: begin m_a = sext(d); m_state = 1; end
      1: begin m_b = sext(d); m_state = 2; end
      2: begin
        m_op = op;
        exp_q.push_back('{a: m_a, b: m_b, op: m_op});
        m_state = 3;
      end
      default: begin m_a = sext(d); m_state = 1; end
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".port_a"}, port_a, m_a);
    chk({tag, ".port_b"}, port_b, m_b);
    chk({tag, ".aluop"}, 32'(aluop), 32'(m_op));
  endtask

  // Clean press: hold low long enough, then release and let it settle.
  // Switches are scrambled after the capture edge; they must be ignored.
  task automatic do_press(input logic [16:0] d, input logic [3:0] op, input int hold);
    sw_data = d;
    sw_op   = op;
    model_press(d, op);
    btn_n = 1'b0;
    cycles(hold);
    sw_data = 17'($urandom);
    sw_op   = 4'($urandom);
    btn_n   = 1'b1;
    cycles(24);
    check_model("press");
    chk("press.op_valid_idle", 32'(op_valid), 32'd0);
  endtask

  // Scoreboard monitor: each op_valid pulse must match the next queued op.
  logic prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (op_valid === 1'b1) begin
      op_t e;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL op_valid_width: got high 2+ cycles expected 1 cycle");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL op_valid_unexpected: got pulse a=%h b=%h op=%h expected none",
                 port_a, port_b, aluop);
      end else begin
        e = exp_q.pop_front();
        if (port_a !== e.a || port_b !== e.b || aluop !== e.op) begin
          errors++;
          $display("FAIL op_valid_data: got a=%h b=%h op=%h expected a=%h b=%h op=%h",
                   port_a, port_b, aluop, e.a, e.b, e.op);
        end
      end
    end
    prev_valid = (op_valid === 1'b1);
  end

  initial begin
    int old_state;
    nRST    = 1'b0;
    btn_n   = 1'b0;
    sw_data = '0;
    sw_op   = '0;
    model_reset();

    // Reset with the button held: nothing may register.
    cycles(2);
    check_model("reset");
    chk("reset.op_valid", 32'(op_valid), 32'd0);
    btn_n = 1'b1;
    nRST  = 1'b1;
    cycles(30);
    check_model("post_reset");

    // Full sequence with fixed values.
    do_press(17'h1_0005, 4'h0, 20);
    chk("seq.port_a_const", port_a, 32'hFFFF_0005);
    do_press(17'h0_0003, 4'h0, 20);
    chk("seq.port_b_const", port_b, 32'h0000_0003);
    do_press(17'h0_0000, 4'h2, 20);
    chk("seq.aluop_const", 32'(aluop), 32'd2);
    chk("seq.state_show", 32'(state), 32'd3);

    // Reload from SHOW: only port_a changes.
    do_press(17'h0_7FFF, 4'h9, 20);
    chk("show.port_a_const", port_a, 32'h0000_7FFF);
    chk("show.port_b_hold", port_b, 32'h0000_0003);
    chk("show.state", 32'(state), 32'd1);

    // Bounce shorter than the debounce window.
    btn_n = 1'b0; cycles(5);
    btn_n = 1'b1; cycles(3);
    btn_n = 1'b0; cycles(5);
    btn_n = 1'b1; cycles(30);
    check_model("bounce");

    // Long hold: one advance, exactly on edge 18 after the fall.
    old_state = m_state;
    sw_data = 17'h1_2345;
    model_press(sw_data, sw_op);
    btn_n = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      cycles(1);
      if (i == 17) chk("hold.edge17", 32'(state), 32'(old_state));
      if (i == 18) chk("hold.edge18", 32'(state), 32'(m_state));
    end
    check_model("hold");
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b1; cycles(3);
      btn_n = 1'b0; cycles(3);
    end
    btn_n = 1'b1;
    cycles(40);
    check_model("release_bounce");

    // Reset on the same edge as the LOAD_OP press.
    chk("midop.state_loadop", 32'(state), 32'd2);
    sw_op = 4'hA;
    btn_n = 1'b0;
    cycles(17);
    nRST  = 1'b0;
    btn_n = 1'b1;
    cycles(1);
    model_reset();
    check_model("midop_reset");
    nRST = 1'b1;
    cycles(30);
    check_model("midop_after");

    // Randomized presses with occasional sub-threshold glitches.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        btn_n = 1'b0; cycles($urandom_range(1, 12));
        btn_n = 1'b1; cycles(20);
      end
      do_press(17'($urandom), 4'($urandom), $urandom_range(18, 40));
    end

    cycles(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
